control_unit_param: RTL

//  Parametrised multi-cycle control FSM for the accumulator processor. Fetches from IM, decodes

---
 rtl/control_unit_param.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/control_unit_param.sv
// control_unit_param: multi-cycle control FSM for the accumulator processor.
// Define CU_SINGLE_STEP_EN to add the step port and a PAUSE state between instructions.
module control_unit_param #(
    parameter  int NREG = 4,
    parameter  int OPW  = 6,
    parameter  int IW   = 16,
    localparam int NBUS = 8 + NREG,
    localparam int SELW = $clog2(NBUS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            z,
    input  logic [IW-1:0]   instruction,
    input  logic            alu_done,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [2:0]      alu_op,
    output logic [SELW-1:0] read_en,
    output logic [NBUS-1:0] write_en,
    output logic [NBUS-1:0] inc_en,
    output logic [NBUS-1:0] clr_en,
    output logic            end_process,
    output logic            illegal_op
);

    localparam int IDX_PC = 1;
    localparam int IDX_AR = 2;
    localparam int IDX_IR = 3;
    localparam int IDX_AC = 4;
    localparam int IDX_R0 = 5;
    localparam int IDX_IM = 6 + NREG;
    localparam int IDX_DM = 7 + NREG;

    typedef enum logic [4:0] {
        S_START, S_FETCH1, S_FETCH2, S_NOP,
        S_LDAC1, S_LDIAC1, S_LD2, S_STAC,
        S_MVACAR, S_MVACR, S_MVRAC, S_ALU,
        S_INAC, S_CLAC, S_JCHK, S_JMP,
        S_HALT
`ifdef CU_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t     r_state;
    logic [3:0] r_k;
    logic [2:0] r_alu;
    logic       r_jz;
    logic       r_illegal;

    state_t         w_fetch;
    logic [OPW-1:0] w_op;
    logic [3:0]     w_k;

    assign w_op = instruction[OPW-1:0];
    assign w_k  = {1'b0, instruction[OPW+2:OPW]} + 4'd1;

`ifdef CU_SINGLE_STEP_EN
    assign w_fetch = S_PAUSE;
`else
    assign w_fetch = S_FETCH1;
`endif

    if (IW > OPW + 3) begin : g_hi
        logic w_unused_hi;
        assign w_unused_hi = ^instruction[IW-1:OPW+3];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_START;
            r_k       <= 4'd1;
            r_alu     <= 3'd0;
            r_jz      <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                S_START:  r_state <= S_FETCH1;
                S_FETCH1: r_state <= S_FETCH2;
                S_FETCH2: begin
                    if (w_op > OPW'(15)) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end else begin
                        unique case (w_op[3:0])
                            4'd0:  r_state <= S_NOP;
                            4'd1:  r_state <= S_LDAC1;
                            4'd2:  r_state <= S_LDIAC1;
                            4'd3:  r_state <= S_STAC;
                            4'd4:  r_state <= S_MVACAR;
                            4'd5, 4'd6: begin
                                r_k <= w_k;
                                if (w_k > 4'(NREG)) begin
                                    r_state   <= S_HALT;
                                    r_illegal <= 1'b1;
                                end else if (w_op[3:0] == 4'd5) begin
                                    r_state <= S_MVACR;
                                end else begin
                                    r_state <= S_MVRAC;
                                end
                            end
                            4'd7, 4'd8, 4'd9, 4'd10: begin
                                r_alu   <= 3'(w_op[3:0] - 4'd6);
                                r_state <= S_ALU;
                            end
                            4'd11: r_state <= S_INAC;
                            4'd12: r_state <= S_CLAC;
                            4'd13: begin
                                r_jz    <= 1'b0;
                                r_state <= S_JCHK;
                            end
                            4'd14: begin
                                r_jz    <= 1'b1;
                                r_state <= S_JCHK;
                            end
                            default: r_state <= S_HALT;
                        endcase
                    end
                end
                S_LDAC1, S_LDIAC1: r_state <= S_LD2;
                S_ALU: if (alu_done) r_state <= w_fetch;
                // JPNZ jumps on z=0, JMPZ on z=1
                S_JCHK: r_state <= (z == r_jz) ? S_JMP : w_fetch;
                S_HALT: r_state <= S_HALT;
`ifdef CU_SINGLE_STEP_EN
                S_PAUSE: if (step) r_state <= S_FETCH1;
`endif
                default: r_state <= w_fetch;
            endcase
        end
    end

    function automatic logic [NBUS-1:0] bit_at(input int idx);
        return NBUS'(1) << idx;
    endfunction

    always_comb begin
        alu_op   = 3'd0;
        read_en  = '0;
        write_en = '0;
        inc_en   = '0;
        clr_en   = '0;
        unique case (r_state)
            S_START:  clr_en = bit_at(IDX_PC) | bit_at(IDX_AR) | bit_at(IDX_AC);
            S_FETCH1: begin
                read_en  = SELW'(IDX_IM);
                write_en = bit_at(IDX_IR);
            end
            S_FETCH2: inc_en = bit_at(IDX_PC);
            S_LDAC1, S_MVACAR: begin
                read_en  = SELW'(IDX_AC);
                write_en = bit_at(IDX_AR);
            end
            S_LDIAC1: begin
                read_en  = SELW'(IDX_IR);
                write_en = bit_at(IDX_AR);
            end
            S_LD2: begin
                read_en  = SELW'(IDX_DM);
                write_en = bit_at(IDX_AC);
            end
            S_STAC: begin
                read_en  = SELW'(IDX_AC);
                write_en = bit_at(IDX_DM);
            end
            S_MVACR: begin
                read_en  = SELW'(IDX_AC);
                write_en = bit_at(IDX_R0 + int'(r_k));
            end
            S_MVRAC: begin
                read_en  = SELW'(IDX_R0 + int'(r_k));
                write_en = bit_at(IDX_AC);
            end
            S_ALU: begin
                alu_op = r_alu;
                if (alu_done) write_en = bit_at(IDX_AC);
            end
            S_INAC: inc_en = bit_at(IDX_AC);
            S_CLAC: clr_en = bit_at(IDX_AC);
            S_JMP: begin
                read_en  = SELW'(IDX_IR);
                write_en = bit_at(IDX_PC);
            end
            default: ;
        endcase
    end

    assign end_process = (r_state == S_HALT);
    assign illegal_op  = r_illegal;

endmodule
